// File: rtl/timer_bank.sv
// Bank of N_TIMERS independent up-counting timers. Each timer has a prescaler, reload-on-overflow,
// one-shot mode and a maskable interrupt. Registers are memory-mapped on a simple rd/wr bus.
module timer_bank #(
    parameter int          N_TIMERS = 4,
    parameter int          WIDTH    = 32,
    parameter int          PRE_W    = 16,
    parameter logic [31:0] BASE     = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irqout,
    output logic [N_TIMERS-1:0] irq_vec
);

    logic [WIDTH-1:0]    th  [N_TIMERS];
    logic [WIDTH-1:0]    tl  [N_TIMERS];
    logic [PRE_W-1:0]    pre [N_TIMERS];
    logic [PRE_W-1:0]    pc  [N_TIMERS];
    logic [N_TIMERS-1:0] en, ie, pend, oneshot;

    logic [31:0]         off;
    logic [1:0]          reg_sel;
    logic                stat_sel;
    logic [N_TIMERS-1:0] ch_sel, tick, ovf;
    logic [N_TIMERS-1:0] wr_th, wr_tl, wr_tcon, wr_pre;
    logic                wr_stat;

    // Address decode and per-channel tick/overflow detection.
    always_comb begin
        off      = addr - BASE;
        reg_sel  = off[3:2];
        stat_sel = (off == 32'h0000_0100);
        wr_stat  = wr && stat_sel;
        for (int i = 0; i < N_TIMERS; i++) begin
            ch_sel[i]  = (off[31:4] == 28'(i)) && (off[1:0] == 2'b00);
            wr_th[i]   = wr && ch_sel[i] && (reg_sel == 2'd0);
            wr_tl[i]   = wr && ch_sel[i] && (reg_sel == 2'd1);
            wr_tcon[i] = wr && ch_sel[i] && (reg_sel == 2'd2);
            wr_pre[i]  = wr && ch_sel[i] && (reg_sel == 2'd3);
            tick[i]    = en[i] && (pc[i] == pre[i]);
            ovf[i]     = tick[i] && (tl[i] == '1);
        end
    end

    // NOTE: the register arrays are a handful of flops, not a RAM macro, so they take the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                th[i]  <= '0;
                tl[i]  <= '0;
                pre[i] <= '0;
                pc[i]  <= '0;
            end
            en      <= '0;
            ie      <= '0;
            pend    <= '0;
            oneshot <= '0;
        end else begin
            // NOTE: non-blocking assignments mean an overflow reloads TL from the pre-edge TH.
            for (int i = 0; i < N_TIMERS; i++) begin
                if (wr_th[i])
                    th[i] <= wdata[WIDTH-1:0];

                if (wr_tl[i])
                    tl[i] <= wdata[WIDTH-1:0];
                else if (ovf[i])
                    tl[i] <= th[i];
                else if (tick[i])
                    tl[i] <= tl[i] + WIDTH'(1);

                if (wr_pre[i])
                    pre[i] <= wdata[PRE_W-1:0];

                if (wr_pre[i] || !en[i] || tick[i])
                    pc[i] <= '0;
                else
                    pc[i] <= pc[i] + PRE_W'(1);

                // A TCON write overrides the one-shot auto-disable.
                if (wr_tcon[i])
                    en[i] <= wdata[0];
                else if (ovf[i] && oneshot[i])
                    en[i] <= 1'b0;

                if (wr_tcon[i]) begin
                    ie[i]      <= wdata[1];
                    oneshot[i] <= wdata[3];
                end

                // Setting beats a simultaneous W1C so no interrupt is lost.
                if (ovf[i] && ie[i])
                    pend[i] <= 1'b1;
                else if ((wr_tcon[i] && wdata[2]) || (wr_stat && wdata[i]))
                    pend[i] <= 1'b0;
            end
        end
    end

    assign irq_vec = pend & ie;
    assign irqout  = |irq_vec;

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (stat_sel)
                rdata = 32'(pend);
            for (int i = 0; i < N_TIMERS; i++) begin
                if (ch_sel[i]) begin
                    case (reg_sel)
                        2'd0:    rdata = 32'(th[i]);
                        2'd1:    rdata = 32'(tl[i]);
                        2'd2:    rdata = 32'({oneshot[i], pend[i], ie[i], en[i]});
                        default: rdata = 32'(pre[i]);
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank with the default parameters (4 channels, 32-bit counters).
module tb_timer_bank;

    localparam logic [31:0] B    = 32'h4000_0000;
    localparam logic [31:0] C0   = B;
    localparam logic [31:0] C1   = B + 32'h10;
    localparam logic [31:0] C2   = B + 32'h20;
    localparam logic [31:0] C3   = B + 32'h30;
    localparam logic [31:0] STAT = B + 32'h100;
    localparam logic [31:0] O_TH = 32'h0, O_TL = 32'h4, O_TCON = 32'h8, O_PRE = 32'hC;

    logic        clk, reset, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        irqout;
    logic [3:0]  irq_vec;

    int n_checks = 0;
    int n_fail   = 0;

    timer_bank dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irqout  (irqout),
        .irq_vec (irq_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called in the clock-low phase; the write lands on the next rising edge, returns at the following negedge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    // Combinational read, takes 1 ns; at most four per low phase.
    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd   = 1'b1;
        addr = a;
        #1;
        check(tag, rdata, exp);
        rd   = 1'b0;
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; reset = 1'b0;

        // Reset state, with reads active while reset is held.
        @(negedge clk);
        check("rst_irqout", 32'(irqout), 32'h0);
        check("rst_irq_vec", 32'(irq_vec), 32'h0);
        chk_rd("rst_tl0", C0 + O_TL, 32'h0);
        chk_rd("rst_tcon0", C0 + O_TCON, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Ch0: overflow on the second enabled edge, reload, interrupt, W1C via IRQ_STAT.
        bus_wr(C0 + O_TH, 32'hFFFF_FFF0);
        bus_wr(C0 + O_TL, 32'hFFFF_FFFE);
        bus_wr(C0 + O_TCON, 32'h3);
        chk_rd("a_tl_start", C0 + O_TL, 32'hFFFF_FFFE);
        @(negedge clk);
        chk_rd("a_tl_edge1", C0 + O_TL, 32'hFFFF_FFFF);
        check("a_irq_edge1", 32'(irqout), 32'h0);
        @(negedge clk);
        chk_rd("a_tl_reload", C0 + O_TL, 32'hFFFF_FFF0);
        chk_rd("a_stat", STAT, 32'h1);
        check("a_irqout", 32'(irqout), 32'h1);
        check("a_irq_vec", 32'(irq_vec), 32'h1);
        bus_wr(STAT, 32'h1);
        check("a_irq_clr", 32'(irqout), 32'h0);
        chk_rd("a_tcon_clr", C0 + O_TCON, 32'h3);
        bus_wr(C0 + O_TCON, 32'h0);

        // Ch1: prescaler of 3 gives a tick every 4 cycles, then PRE=0 ticks every cycle.
        bus_wr(C1 + O_PRE, 32'h3);
        bus_wr(C1 + O_TL, 32'h0);
        bus_wr(C1 + O_TCON, 32'h1);
        chk_rd("b_tl_c0", C1 + O_TL, 32'h0);
        repeat (3) @(negedge clk);
        chk_rd("b_tl_c3", C1 + O_TL, 32'h0);
        @(negedge clk);
        chk_rd("b_tl_c4", C1 + O_TL, 32'h1);
        repeat (4) @(negedge clk);
        chk_rd("b_tl_c8", C1 + O_TL, 32'h2);
        bus_wr(C1 + O_PRE, 32'h0);
        chk_rd("b_tl_prewr", C1 + O_TL, 32'h2);
        @(negedge clk);
        chk_rd("b_tl_fast1", C1 + O_TL, 32'h3);
        @(negedge clk);
        chk_rd("b_tl_fast2", C1 + O_TL, 32'h4);
        bus_wr(C1 + O_TCON, 32'h0);
        chk_rd("b_tl_stop", C1 + O_TL, 32'h5);
        repeat (2) @(negedge clk);
        chk_rd("b_tl_held", C1 + O_TL, 32'h5);

        // Ch2: one-shot overflow disables the channel and leaves TL at TH.
        bus_wr(C2 + O_TH, 32'h1234_5678);
        bus_wr(C2 + O_TL, 32'hFFFF_FFFF);
        bus_wr(C2 + O_TCON, 32'hB);
        chk_rd("c_tl_start", C2 + O_TL, 32'hFFFF_FFFF);
        @(negedge clk);
        chk_rd("c_tcon_ovf", C2 + O_TCON, 32'hE);
        chk_rd("c_tl_ovf", C2 + O_TL, 32'h1234_5678);
        check("c_irq_vec", 32'(irq_vec), 32'h4);
        repeat (3) @(negedge clk);
        chk_rd("c_tl_hold", C2 + O_TL, 32'h1234_5678);
        chk_rd("c_tcon_hold", C2 + O_TCON, 32'hE);
        bus_wr(C2 + O_TCON, 32'h4);
        chk_rd("c_tcon_clr", C2 + O_TCON, 32'h0);
        check("c_irqout_clr", 32'(irqout), 32'h0);

        // Ch3: overflow coincident with PEND W1C, then TL write coincident with a tick.
        bus_wr(C3 + O_TL, 32'hFFFF_FFFE);
        bus_wr(C3 + O_TCON, 32'h3);
        @(negedge clk);
        bus_wr(C3 + O_TCON, 32'h7);
        chk_rd("d_tcon_setwin", C3 + O_TCON, 32'h7);
        chk_rd("d_tl_reload", C3 + O_TL, 32'h0);
        check("d_irq_vec", 32'(irq_vec), 32'h8);
        bus_wr(C3 + O_TL, 32'h100);
        chk_rd("d_tl_wrwin", C3 + O_TL, 32'h100);
        @(negedge clk);
        chk_rd("d_tl_next", C3 + O_TL, 32'h101);
        bus_wr(C3 + O_TCON, 32'h4);
        chk_rd("d_tcon_clr", C3 + O_TCON, 32'h0);
        check("d_irq_vec_clr", 32'(irq_vec), 32'h0);

        // Ch0 and Ch1 both raise PEND; IE is then removed from Ch0 only.
        bus_wr(C0 + O_TL, 32'hFFFF_FFFF);
        bus_wr(C0 + O_TCON, 32'hB);
        bus_wr(C1 + O_TL, 32'hFFFF_FFFF);
        bus_wr(C1 + O_TCON, 32'hB);
        @(negedge clk);
        bus_wr(C0 + O_TCON, 32'h8);
        check("e_irq_vec", 32'(irq_vec), 32'h2);
        check("e_irqout", 32'(irqout), 32'h1);
        chk_rd("e_stat", STAT, 32'h3);
        chk_rd("e_tcon0", C0 + O_TCON, 32'hC);
        chk_rd("e_tl0", C0 + O_TL, 32'hFFFF_FFF0);
        @(negedge clk);
        chk_rd("e_tl1", C1 + O_TL, 32'h0);
        chk_rd("e_unmap_ch4", B + 32'h40, 32'h0);
        chk_rd("e_unmap_104", B + 32'h104, 32'h0);
        addr = STAT;
        #1;
        check("e_rd_low", rdata, 32'h0);
        bus_wr(B + 32'h40, 32'hDEAD_BEEF);
        chk_rd("e_th0_kept", C0 + O_TH, 32'hFFFF_FFF0);
        chk_rd("e_tl2_kept", C2 + O_TL, 32'h1234_5678);

        // Reset in the middle of counting with an interrupt active.
        bus_wr(C2 + O_TCON, 32'h1);
        @(negedge clk);
        check("f_irq_before", 32'(irqout), 32'h1);
        reset = 1'b0;
        #1;
        check("f_irqout_rst", 32'(irqout), 32'h0);
        check("f_irq_vec_rst", 32'(irq_vec), 32'h0);
        chk_rd("f_tl2_rst", C2 + O_TL, 32'h0);
        chk_rd("f_stat_rst", STAT, 32'h0);
        chk_rd("f_th0_rst", C0 + O_TH, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_rd("f_tl2_after", C2 + O_TL, 32'h0);
        chk_rd("f_tcon2_after", C2 + O_TCON, 32'h0);

        // Field truncation and TCON reserved bits.
        bus_wr(C3 + O_PRE, 32'hABCD_1234);
        chk_rd("g_pre_trunc", C3 + O_PRE, 32'h1234);
        bus_wr(C3 + O_TCON, 32'hFFFF_FFF8);
        chk_rd("g_tcon_rsvd", C3 + O_TCON, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
